// File: rtl/spell_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spell_mem_arbiter
//  Purpose  : Two-port (CPU / host-debug) arbiter in front of a single
//             handshake memory. One access at a time, round-robin on ties,
//             request fields captured at grant, per-access watchdog that
//             completes a stuck access with 8'hFF and an error flag.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT_W       watchdog width; an access times out after
//                    2^TIMEOUT_W-1 grant cycles without mem_data_ready
//  Ports
//    clk, rst_n      clock (rising edge), synchronous active-low reset
//    cpu_req         CPU request level, held until cpu_ack
//    cpu_addr/wdata  CPU address / write data (8 bit)
//    cpu_type_data   CPU space select: 1 = data, 0 = code
//    cpu_write       CPU write enable
//    cpu_rdata       CPU read data register (holds until next completion)
//    cpu_ack         one-cycle completion pulse
//    cpu_err         timeout flag, updated with each cpu_ack
//    host_*          same set for the host/debug port
//    mem_select      high while an access is presented to memory
//    mem_write       write strobe, only while mem_select is high
//    mem_type_data   space select of the current access
//    mem_addr        address of the current access
//    mem_data_in     write data of the current access
//    mem_data_out    read data from memory
//    mem_data_ready  memory completion, valid while mem_select is high
//    busy            arbiter is not idle
// ============================================================================
module spell_mem_arbiter #(
    parameter int TIMEOUT_W = 10
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       cpu_req,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_type_data,
    input  logic       cpu_write,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ack,
    output logic       cpu_err,

    input  logic       host_req,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    input  logic       host_type_data,
    input  logic       host_write,
    output logic [7:0] host_rdata,
    output logic       host_ack,
    output logic       host_err,

    output logic       mem_select,
    output logic       mem_write,
    output logic       mem_type_data,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data_in,
    input  logic [7:0] mem_data_out,
    input  logic       mem_data_ready,

    output logic       busy
);

    // ------------------------------------------------------------------------
    //  Constants
    // ------------------------------------------------------------------------
    // The counter holds the number of grant cycles already completed, so the
    // access has spent 2^TIMEOUT_W-1 cycles in grant when the counter reads
    // 2^TIMEOUT_W-2 at a clock edge. Comparing against that value lets the
    // counter stay TIMEOUT_W bits wide without ever wrapping.
    localparam logic [TIMEOUT_W-1:0] c_WD_LAST =
        TIMEOUT_W'((64'd1 << TIMEOUT_W) - 64'd2);

    localparam logic [7:0] c_TIMEOUT_DATA = 8'hFF;

    // ------------------------------------------------------------------------
    //  State machine
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_CPU  = 2'd1,
        GRANT_HOST = 2'd2,
        RELEASE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------------
    //  Registers
    // ------------------------------------------------------------------------
    // Captured request fields of the port being served
    logic [7:0]           r_addr;
    logic [7:0]           r_wdata;
    logic                 r_type_data;
    logic                 r_write;

    logic [TIMEOUT_W-1:0] r_wd_cnt;
    // 1 = host was served last, so a tie goes to the CPU
    logic                 r_last_host;

    logic [7:0]           r_cpu_rdata;
    logic                 r_cpu_ack;
    logic                 r_cpu_err;
    logic [7:0]           r_host_rdata;
    logic                 r_host_ack;
    logic                 r_host_err;

    // ------------------------------------------------------------------------
    //  Combinational control
    // ------------------------------------------------------------------------
    logic       w_grant_cpu;
    logic       w_grant_host;
    logic       w_in_grant;
    logic       w_wd_expired;
    logic       w_complete;
    logic [7:0] w_result_data;
    logic       w_result_err;

    assign w_in_grant   = (r_state == GRANT_CPU) || (r_state == GRANT_HOST);
    assign w_wd_expired = (r_wd_cnt == c_WD_LAST);

    // A ready memory always wins over an expiring watchdog in the same cycle.
    assign w_result_data = mem_data_ready ? mem_data_out : c_TIMEOUT_DATA;
    assign w_result_err  = ~mem_data_ready;

    always_comb begin
        w_state_next = r_state;
        w_grant_cpu  = 1'b0;
        w_grant_host = 1'b0;
        w_complete   = 1'b0;

        case (r_state)
            IDLE: begin
                // CPU takes the slot when alone, or on a tie after a host access
                if (cpu_req && (!host_req || r_last_host)) begin
                    w_state_next = GRANT_CPU;
                    w_grant_cpu  = 1'b1;
                end else if (host_req) begin
                    w_state_next = GRANT_HOST;
                    w_grant_host = 1'b1;
                end
            end

            GRANT_CPU, GRANT_HOST: begin
                if (mem_data_ready || w_wd_expired) begin
                    w_state_next = RELEASE;
                    w_complete   = 1'b1;
                end
            end

            RELEASE: begin
                // Single deselected cycle between any two accesses
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    //  State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    //  Request capture and watchdog
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr      <= 8'h00;
            r_wdata     <= 8'h00;
            r_type_data <= 1'b0;
            r_write     <= 1'b0;
            r_wd_cnt    <= '0;
        end else begin
            if (w_grant_cpu) begin
                r_addr      <= cpu_addr;
                r_wdata     <= cpu_wdata;
                r_type_data <= cpu_type_data;
                r_write     <= cpu_write;
                r_wd_cnt    <= '0;
            end else if (w_grant_host) begin
                r_addr      <= host_addr;
                r_wdata     <= host_wdata;
                r_type_data <= host_type_data;
                r_write     <= host_write;
                r_wd_cnt    <= '0;
            end else if (w_in_grant) begin
                r_wd_cnt    <= r_wd_cnt + TIMEOUT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    //  Completion: read data, ack pulse, error flag, fairness pointer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cpu_rdata  <= 8'h00;
            r_cpu_ack    <= 1'b0;
            r_cpu_err    <= 1'b0;
            r_host_rdata <= 8'h00;
            r_host_ack   <= 1'b0;
            r_host_err   <= 1'b0;
            r_last_host  <= 1'b1;
        end else begin
            // Acks are single-cycle pulses; rdata and err hold between them
            r_cpu_ack  <= 1'b0;
            r_host_ack <= 1'b0;

            if (w_complete) begin
                if (r_state == GRANT_CPU) begin
                    r_cpu_rdata <= w_result_data;
                    r_cpu_err   <= w_result_err;
                    r_cpu_ack   <= 1'b1;
                    r_last_host <= 1'b0;
                end else begin
                    r_host_rdata <= w_result_data;
                    r_host_err   <= w_result_err;
                    r_host_ack   <= 1'b1;
                    r_last_host  <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    //  Outputs
    // ------------------------------------------------------------------------
    assign mem_select    = w_in_grant;
    assign mem_write     = r_write & w_in_grant;
    assign mem_type_data = r_type_data;
    assign mem_addr      = r_addr;
    assign mem_data_in   = r_wdata;

    assign cpu_rdata     = r_cpu_rdata;
    assign cpu_ack       = r_cpu_ack;
    assign cpu_err       = r_cpu_err;
    assign host_rdata    = r_host_rdata;
    assign host_ack      = r_host_ack;
    assign host_err      = r_host_err;

    assign busy          = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spell_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_spell_mem_arbiter
//  Purpose  : Self-checking bench for spell_mem_arbiter. A behavioural memory
//             with programmable latency answers the main instance; expected
//             accesses are queued in service order and checked while the
//             memory is selected and when each ack appears. A second
//             instance with a 4-bit watchdog covers the timeout path.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spell_mem_arbiter;

    // ------------------------------------------------------------------------
    //  Clock / reset
    // ------------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ------------------------------------------------------------------------
    //  Main instance signals
    // ------------------------------------------------------------------------
    logic       cpu_req, cpu_type_data, cpu_write;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       cpu_ack, cpu_err;
    logic       host_req, host_type_data, host_write;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic       host_ack, host_err;
    logic       mem_select, mem_write, mem_type_data;
    logic [7:0] mem_addr, mem_data_in, mem_data_out;
    logic       mem_data_ready = 1'b0;
    logic       busy;

    spell_mem_arbiter #(.TIMEOUT_W(10)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req        (cpu_req),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_type_data  (cpu_type_data),
        .cpu_write      (cpu_write),
        .cpu_rdata      (cpu_rdata),
        .cpu_ack        (cpu_ack),
        .cpu_err        (cpu_err),
        .host_req       (host_req),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_type_data (host_type_data),
        .host_write     (host_write),
        .host_rdata     (host_rdata),
        .host_ack       (host_ack),
        .host_err       (host_err),
        .mem_select     (mem_select),
        .mem_write      (mem_write),
        .mem_type_data  (mem_type_data),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_data_ready (mem_data_ready),
        .busy           (busy)
    );

    // ------------------------------------------------------------------------
    //  Short-watchdog instance (memory never answers unless forced)
    // ------------------------------------------------------------------------
    logic       t_host_req = 1'b0;
    logic       t_ready    = 1'b0;
    logic [7:0] t_cpu_rdata, t_host_rdata, t_mem_addr, t_mem_data_in;
    logic       t_cpu_ack, t_cpu_err, t_host_ack, t_host_err;
    logic       t_mem_select, t_mem_write, t_mem_type_data, t_busy;

    spell_mem_arbiter #(.TIMEOUT_W(4)) u_dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req        (1'b0),
        .cpu_addr       (8'h00),
        .cpu_wdata      (8'h00),
        .cpu_type_data  (1'b0),
        .cpu_write      (1'b0),
        .cpu_rdata      (t_cpu_rdata),
        .cpu_ack        (t_cpu_ack),
        .cpu_err        (t_cpu_err),
        .host_req       (t_host_req),
        .host_addr      (8'h07),
        .host_wdata     (8'h00),
        .host_type_data (1'b1),
        .host_write     (1'b0),
        .host_rdata     (t_host_rdata),
        .host_ack       (t_host_ack),
        .host_err       (t_host_err),
        .mem_select     (t_mem_select),
        .mem_write      (t_mem_write),
        .mem_type_data  (t_mem_type_data),
        .mem_addr       (t_mem_addr),
        .mem_data_in    (t_mem_data_in),
        .mem_data_out   (8'h5A),
        .mem_data_ready (t_ready),
        .busy           (t_busy)
    );

    // ------------------------------------------------------------------------
    //  Checking
    // ------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    //  Behavioural memory: unwritten locations return a fixed pattern
    // ------------------------------------------------------------------------
    int         mem_lat   = 1;
    int         sel_cnt_m = 0;
    bit [7:0]   wr_arr   [512];
    bit         wr_valid [512];
    logic [8:0] m_idx;

    function automatic logic [7:0] pat(input logic [8:0] idx);
        return idx[7:0] ^ 8'h7D ^ {7'd0, idx[8]};
    endfunction

    function automatic logic [7:0] mem_peek(input logic [8:0] idx);
        return wr_valid[idx] ? wr_arr[idx] : pat(idx);
    endfunction

    always_comb begin
        m_idx        = {mem_type_data, mem_addr};
        mem_data_out = wr_valid[m_idx] ? wr_arr[m_idx] : pat(m_idx);
    end

    // Ready rises mem_lat cycles after select is first seen, drops once
    // select is gone; a write lands on the edge the arbiter completes.
    always @(posedge clk) begin
        if (mem_select !== 1'b1) begin
            sel_cnt_m      <= 0;
            mem_data_ready <= 1'b0;
        end else begin
            sel_cnt_m <= sel_cnt_m + 1;
            if (sel_cnt_m + 1 >= mem_lat) mem_data_ready <= 1'b1;
            if (mem_data_ready && mem_write) begin
                wr_arr[m_idx]   <= mem_data_in;
                wr_valid[m_idx] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    //  Scoreboard (entries in expected service order)
    // ------------------------------------------------------------------------
    typedef struct {
        bit         is_host;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         typ;
        bit         wr;
        logic [7:0] rdata;
        bit         err;
        int         sel_cycles;
    } exp_t;

    exp_t exp_q[$];

    task automatic expect_txn(input bit h, input logic [7:0] a, input logic [7:0] wd,
                              input bit typ, input bit wr, input int selc);
        exp_t e;
        e.is_host    = h;
        e.addr       = a;
        e.wdata      = wd;
        e.typ        = typ;
        e.wr         = wr;
        e.rdata      = mem_peek({typ, a});
        e.err        = 1'b0;
        e.sel_cycles = selc;
        exp_q.push_back(e);
    endtask

    int mon_sel       = 0;
    bit prev_cpu_ack  = 1'b0;
    bit prev_host_ack = 1'b0;

    always @(negedge clk) begin : p_monitor
        exp_t e;
        bit   ackd;
        ackd = (cpu_ack === 1'b1) || (host_ack === 1'b1);

        if (mem_select === 1'b1) begin
            mon_sel = mon_sel + 1;
            if (exp_q.size() == 0) begin
                check_eq("sel_unexpected", mem_select, 0);
            end else begin
                check_eq("mem_addr",      mem_addr,      exp_q[0].addr);
                check_eq("mem_data_in",   mem_data_in,   exp_q[0].wdata);
                check_eq("mem_type_data", mem_type_data, exp_q[0].typ);
                check_eq("mem_write",     mem_write,     exp_q[0].wr);
            end
        end else if (!ackd) begin
            mon_sel = 0;
        end

        if (mem_select === 1'b0 && mem_write !== 1'b0)
            check_eq("mem_write_gate", mem_write, 0);
        if (cpu_ack === 1'b1 && host_ack === 1'b1)
            check_eq("ack_both", cpu_ack & host_ack, 0);
        if (prev_cpu_ack && cpu_ack === 1'b1)
            check_eq("cpu_ack_width", cpu_ack, 0);
        if (prev_host_ack && host_ack === 1'b1)
            check_eq("host_ack_width", host_ack, 0);

        if (ackd) begin
            if (exp_q.size() == 0) begin
                check_eq("ack_unexpected", ackd, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("ack_port",      host_ack, e.is_host);
                check_eq("ack_rdata",     e.is_host ? host_rdata : cpu_rdata, e.rdata);
                check_eq("ack_err",       e.is_host ? host_err   : cpu_err,   e.err);
                check_eq("sel_cycles",    mon_sel, e.sel_cycles);
                check_eq("release_desel", mem_select, 0);
            end
            mon_sel = 0;
        end

        prev_cpu_ack  = (cpu_ack  === 1'b1);
        prev_host_ack = (host_ack === 1'b1);
    end

    // ------------------------------------------------------------------------
    //  Requester driver: raise req, optionally disturb the request fields
    //  after grant, wait for ack (bounded), drop req.
    // ------------------------------------------------------------------------
    task automatic txn(input bit h, input logic [7:0] a, input logic [7:0] wd,
                       input bit typ, input bit wr, input bit scramble, output int lat);
        bit seen;
        if (h) begin
            host_addr = a; host_wdata = wd; host_type_data = typ; host_write = wr; host_req = 1'b1;
        end else begin
            cpu_addr = a; cpu_wdata = wd; cpu_type_data = typ; cpu_write = wr; cpu_req = 1'b1;
        end
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (scramble && i == 1) begin
                if (h) begin
                    host_addr = ~a; host_wdata = ~wd; host_type_data = ~typ; host_write = ~wr;
                end else begin
                    cpu_addr = ~a; cpu_wdata = ~wd; cpu_type_data = ~typ; cpu_write = ~wr;
                end
            end
            seen = h ? (host_ack === 1'b1) : (cpu_ack === 1'b1);
        end
        check_eq(h ? "host_ack_seen" : "cpu_ack_seen", seen, 1);
        if (h) host_req = 1'b0;
        else   cpu_req  = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    //  Global time limit
    // ------------------------------------------------------------------------
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    //  Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int lat_a, lat_b, gap, tcnt;
        bit seen, stray;

        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00; cpu_type_data = 1'b0; cpu_write = 1'b0;
        host_req = 1'b0; host_addr = 8'h00; host_wdata = 8'h00; host_type_data = 1'b0; host_write = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_mem_select",    mem_select,    0);
        check_eq("rst_mem_write",     mem_write,     0);
        check_eq("rst_mem_addr",      mem_addr,      0);
        check_eq("rst_mem_data_in",   mem_data_in,   0);
        check_eq("rst_mem_type_data", mem_type_data, 0);
        check_eq("rst_cpu_ack",       cpu_ack,       0);
        check_eq("rst_host_ack",      host_ack,      0);
        check_eq("rst_cpu_err",       cpu_err,       0);
        check_eq("rst_host_err",      host_err,      0);
        check_eq("rst_cpu_rdata",     cpu_rdata,     0);
        check_eq("rst_host_rdata",    host_rdata,    0);
        check_eq("rst_busy",          busy,          0);
        check_eq("rst_busy_w4",       t_busy,        0);
        rst_n = 1'b1;
        @(negedge clk);

        // CPU data write, memory ready one cycle after select
        mem_lat = 1;
        expect_txn(0, 8'h10, 8'hA5, 1, 1, 2);
        txn(0, 8'h10, 8'hA5, 1, 1, 0, lat_a);
        check_eq("cpu_latency", lat_a, 3);
        check_eq("cpu_err_after_write", cpu_err, 0);

        // Host code read of address 3
        expect_txn(1, 8'h03, 8'h00, 0, 0, 2);
        txn(1, 8'h03, 8'h00, 0, 0, 0, lat_a);
        check_eq("host_rdata_7e", host_rdata, 8'h7E);
        check_eq("host_cpu_ack_quiet", cpu_ack, 0);

        // Tie right after reset: CPU first, then host; next tie CPU again
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_txn(0, 8'h20, 8'h00, 0, 0, 2);
        expect_txn(1, 8'h21, 8'h11, 1, 1, 2);
        fork
            txn(0, 8'h20, 8'h00, 0, 0, 0, lat_a);
            txn(1, 8'h21, 8'h11, 1, 1, 0, lat_b);
        join
        expect_txn(0, 8'h30, 8'h33, 1, 1, 2);
        expect_txn(1, 8'h31, 8'h00, 0, 0, 2);
        fork
            txn(0, 8'h30, 8'h33, 1, 1, 0, lat_a);
            txn(1, 8'h31, 8'h00, 0, 0, 0, lat_b);
        join

        // CPU served alone, so the following tie goes to the host
        expect_txn(0, 8'h40, 8'h00, 0, 0, 2);
        txn(0, 8'h40, 8'h00, 0, 0, 0, lat_a);
        expect_txn(1, 8'h41, 8'h00, 1, 0, 2);
        expect_txn(0, 8'h42, 8'h00, 0, 0, 2);
        fork
            txn(0, 8'h42, 8'h00, 0, 0, 0, lat_a);
            txn(1, 8'h41, 8'h00, 1, 0, 0, lat_b);
        join

        // Read back the earlier write with inputs disturbed mid-access
        mem_lat = 4;
        expect_txn(0, 8'h10, 8'h00, 1, 0, 5);
        txn(0, 8'h10, 8'h00, 1, 0, 1, lat_a);
        check_eq("readback_a5", cpu_rdata, 8'hA5);

        // Request held across ack: one RELEASE, one IDLE, then a new access
        mem_lat = 1;
        expect_txn(0, 8'h60, 8'h00, 0, 0, 2);
        expect_txn(0, 8'h60, 8'h00, 0, 0, 2);
        cpu_addr = 8'h60; cpu_wdata = 8'h00; cpu_type_data = 1'b0; cpu_write = 1'b0; cpu_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (cpu_ack === 1'b1);
        end
        check_eq("held_first_ack", seen, 1);
        @(negedge clk);
        check_eq("held_idle_desel", mem_select, 0);
        check_eq("held_idle_busy",  busy,       0);
        gap  = 1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            gap++;
            seen = (cpu_ack === 1'b1);
        end
        cpu_req = 1'b0;
        check_eq("held_second_ack", seen, 1);
        check_eq("held_ack_gap", gap, 4);

        // Slow memory (512-cycle init) still inside the 10-bit watchdog
        mem_lat = 512;
        expect_txn(0, 8'h70, 8'h00, 0, 0, 513);
        txn(0, 8'h70, 8'h00, 0, 0, 0, lat_a);
        check_eq("slow_err", cpu_err, 0);

        // Reset pulse in the middle of a CPU grant
        mem_lat = 20;
        expect_txn(0, 8'h50, 8'h00, 0, 0, 21);
        cpu_addr = 8'h50; cpu_wdata = 8'h00; cpu_type_data = 1'b0; cpu_write = 1'b0; cpu_req = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("abort_pre_select", mem_select, 1);
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        check_eq("abort_select", mem_select, 0);
        check_eq("abort_busy",   busy,       0);
        check_eq("abort_ack",    cpu_ack,    0);
        exp_q.delete();
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) stray = 1'b1;
        end
        check_eq("abort_no_ack", stray, 0);
        mem_lat = 1;
        expect_txn(0, 8'h51, 8'h00, 1, 0, 2);
        txn(0, 8'h51, 8'h00, 1, 0, 0, lat_a);
        check_eq("abort_recover_err", cpu_err, 0);

        // 4-bit watchdog: ready in IDLE is ignored, then a stuck access
        t_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("w4_idle_ready_busy", t_busy,       0);
        check_eq("w4_idle_ready_ack",  t_host_ack,   0);
        check_eq("w4_idle_ready_sel",  t_mem_select, 0);
        t_ready    = 1'b0;
        t_host_req = 1'b1;
        tcnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (t_mem_select === 1'b1) tcnt++;
            seen = (t_host_ack === 1'b1);
        end
        t_host_req = 1'b0;
        check_eq("w4_ack_seen",    seen,         1);
        check_eq("w4_grant_cycles", tcnt,        15);
        check_eq("w4_err",         t_host_err,   1);
        check_eq("w4_rdata",       t_host_rdata, 8'hFF);
        check_eq("w4_cpu_ack",     t_cpu_ack,    0);
        check_eq("w4_release_sel", t_mem_select, 0);
        repeat (3) @(negedge clk);
        check_eq("w4_err_hold",    t_host_err,   1);
        check_eq("w4_rdata_hold",  t_host_rdata, 8'hFF);
        check_eq("w4_ack_pulse",   t_host_ack,   0);

        repeat (2) @(negedge clk);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
